// File: rtl/cond_unit.sv
// Condition unit for an ARM-style datapath.
// Evaluates the condition field against one of NBANK NZCV flag banks and
// latches the result into CondEx. It gates the controller's write requests
// with that latched result, updates flags, saves and restores flags, and
// counts instructions that were skipped because their condition failed.
module cond_unit #(
    parameter int NBANK   = 2,
    parameter int BSW     = (NBANK > 1) ? $clog2(NBANK) : 1,
    parameter int CNT_W   = 16,
    parameter bit NV_EXEC = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       Cond,
    input  logic [3:0]       ALUFlags,
    input  logic [1:0]       FlagW,
    input  logic [BSW-1:0]   BankSel,
    input  logic             Latch,
    input  logic             PCS,
    input  logic             NextPC,
    input  logic             RegW,
    input  logic             MemW,
    input  logic             FlagSave,
    input  logic             FlagRestore,
    input  logic             CntClr,
    output logic             PCWrite,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic             CondEx,
    output logic [3:0]       Flags,
    output logic [CNT_W-1:0] SkipCnt
);

    logic [3:0]       bank [NBANK];
    logic [3:0]       saved;
    logic             cond_q;
    logic [CNT_W-1:0] skip_q;
    logic [3:0]       flags_sel;
    logic             cond_pass;
    logic             n_f, z_f, c_f, v_f, ge;

    assign n_f = flags_sel[3];
    assign z_f = flags_sel[2];
    assign c_f = flags_sel[1];
    assign v_f = flags_sel[0];
    assign ge  = (n_f == v_f);

    // Route the selected bank to the output. A selector value that has no
    // bank behind it (NBANK not a power of two) reads as zero.
    always_comb begin
        flags_sel = 4'b0000;
        for (int i = 0; i < NBANK; i++) begin
            if (BankSel == BSW'(i)) flags_sel = bank[i];
        end
    end

    // Decode the condition field against the pre-edge flags of the selected bank.
    always_comb begin
        cond_pass = 1'b0;
        case (Cond)
            4'b0000: cond_pass = z_f;
            4'b0001: cond_pass = !z_f;
            4'b0010: cond_pass = c_f;
            4'b0011: cond_pass = !c_f;
            4'b0100: cond_pass = n_f;
            4'b0101: cond_pass = !n_f;
            4'b0110: cond_pass = v_f;
            4'b0111: cond_pass = !v_f;
            4'b1000: cond_pass = c_f && !z_f;
            4'b1001: cond_pass = !(c_f && !z_f);
            4'b1010: cond_pass = ge;
            4'b1011: cond_pass = !ge;
            4'b1100: cond_pass = !z_f && ge;
            4'b1101: cond_pass = !(!z_f && ge);
            4'b1110: cond_pass = 1'b1;
            4'b1111: cond_pass = NV_EXEC;
            default: cond_pass = 1'b0;
        endcase
    end

    // Update the flag banks. Only the selected bank changes. A restore wins
    // over a flag write on the same edge. Flag writes are gated by the
    // CondEx value that was latched earlier, not by the one being latched now.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NBANK; i++) bank[i] <= 4'b0000;
        end else begin
            for (int i = 0; i < NBANK; i++) begin
                if (BankSel == BSW'(i)) begin
                    if (FlagRestore) begin
                        bank[i] <= saved;
                    end else begin
                        if (FlagW[1] && cond_q) bank[i][3:2] <= ALUFlags[3:2];
                        if (FlagW[0] && cond_q) bank[i][1:0] <= ALUFlags[1:0];
                    end
                end
            end
        end
    end

    // Copy the selected bank into the saved register. When a restore happens
    // on the same edge, the bank and the saved register swap contents.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)        saved <= 4'b0000;
        else if (FlagSave) saved <= flags_sel;
    end

    // Latch the condition result during decode.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)     cond_q <= 1'b0;
        else if (Latch) cond_q <= cond_pass;
    end

    // Count latched instructions whose condition failed. The count saturates
    // at all ones, and a clear wins over an increment on the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            skip_q <= '0;
        end else if (CntClr) begin
            skip_q <= '0;
        end else if (Latch && !cond_pass && (skip_q != '1)) begin
            skip_q <= skip_q + CNT_W'(1);
        end
    end

    assign PCWrite  = NextPC | (PCS & cond_q);
    assign RegWrite = RegW & cond_q;
    assign MemWrite = MemW & cond_q;
    assign CondEx   = cond_q;
    assign Flags    = flags_sel;
    assign SkipCnt  = skip_q;

endmodule

// File: tb/tb_cond_unit.sv
// Directed bench for cond_unit. It drives three instances from the same
// inputs: the default configuration, NV_EXEC=1, and CNT_W=2.
module tb_cond_unit;

    logic       clk, reset;
    logic [3:0] cond, alu_flags;
    logic [1:0] flag_w;
    logic       bank_sel, latch, pcs, next_pc, reg_w, mem_w;
    logic       flag_save, flag_restore, cnt_clr;

    logic       pc_write [3];
    logic       reg_write [3];
    logic       mem_write [3];
    logic       cond_ex [3];
    logic [3:0] flags [3];
    logic [15:0] skip0, skip1;
    logic [1:0]  skip2;

    int n_cmp = 0;
    int n_bad = 0;

    cond_unit #(.NBANK(2), .CNT_W(16), .NV_EXEC(1'b0)) dut0 (
        .clk(clk), .reset(reset), .Cond(cond), .ALUFlags(alu_flags), .FlagW(flag_w),
        .BankSel(bank_sel), .Latch(latch), .PCS(pcs), .NextPC(next_pc), .RegW(reg_w),
        .MemW(mem_w), .FlagSave(flag_save), .FlagRestore(flag_restore), .CntClr(cnt_clr),
        .PCWrite(pc_write[0]), .RegWrite(reg_write[0]), .MemWrite(mem_write[0]),
        .CondEx(cond_ex[0]), .Flags(flags[0]), .SkipCnt(skip0));

    cond_unit #(.NBANK(2), .CNT_W(16), .NV_EXEC(1'b1)) dut1 (
        .clk(clk), .reset(reset), .Cond(cond), .ALUFlags(alu_flags), .FlagW(flag_w),
        .BankSel(bank_sel), .Latch(latch), .PCS(pcs), .NextPC(next_pc), .RegW(reg_w),
        .MemW(mem_w), .FlagSave(flag_save), .FlagRestore(flag_restore), .CntClr(cnt_clr),
        .PCWrite(pc_write[1]), .RegWrite(reg_write[1]), .MemWrite(mem_write[1]),
        .CondEx(cond_ex[1]), .Flags(flags[1]), .SkipCnt(skip1));

    cond_unit #(.NBANK(2), .CNT_W(2), .NV_EXEC(1'b0)) dut2 (
        .clk(clk), .reset(reset), .Cond(cond), .ALUFlags(alu_flags), .FlagW(flag_w),
        .BankSel(bank_sel), .Latch(latch), .PCS(pcs), .NextPC(next_pc), .RegW(reg_w),
        .MemW(mem_w), .FlagSave(flag_save), .FlagRestore(flag_restore), .CntClr(cnt_clr),
        .PCWrite(pc_write[2]), .RegWrite(reg_write[2]), .MemWrite(mem_write[2]),
        .CondEx(cond_ex[2]), .Flags(flags[2]), .SkipCnt(skip2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Condition reference written as even/odd pairs: an odd code is the
    // inverse of its even partner, except for code 1111.
    function automatic logic exp_cond(input logic [3:0] c, input logic [3:0] f, input logic nv);
        logic base;
        case (c[3:1])
            3'd0: base = f[2];
            3'd1: base = f[1];
            3'd2: base = f[3];
            3'd3: base = f[0];
            3'd4: base = f[1] & ~f[2];
            3'd5: base = (f[3] == f[0]);
            3'd6: base = ~f[2] & (f[3] == f[0]);
            default: base = 1'b1;
        endcase
        if (c == 4'b1111) return nv;
        return c[0] ? ~base : base;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; cond = 4'hE; alu_flags = 4'hF; flag_w = 2'b11; bank_sel = 1'b0;
        latch = 1'b1; pcs = 1'b1; next_pc = 1'b1; reg_w = 1'b1; mem_w = 1'b1;
        flag_save = 1'b0; flag_restore = 1'b0; cnt_clr = 1'b0;
        step(); step();
        n_cmp++; if (pc_write[0] !== 1'b1) begin n_bad++; $display("FAIL rst_pcwrite got=%b exp=1", pc_write[0]); end
        n_cmp++; if (reg_write[0] !== 1'b0) begin n_bad++; $display("FAIL rst_regwrite got=%b exp=0", reg_write[0]); end
        n_cmp++; if (mem_write[0] !== 1'b0) begin n_bad++; $display("FAIL rst_memwrite got=%b exp=0", mem_write[0]); end
        n_cmp++; if (flags[0] !== 4'b0000) begin n_bad++; $display("FAIL rst_flags got=%b exp=0000", flags[0]); end
        n_cmp++; if (cond_ex[0] !== 1'b0) begin n_bad++; $display("FAIL rst_condex got=%b exp=0", cond_ex[0]); end
        n_cmp++; if (skip0 !== 16'd0) begin n_bad++; $display("FAIL rst_skip got=%0d exp=0", skip0); end
        latch = 1'b0; flag_w = 2'b00; pcs = 1'b0; next_pc = 1'b0; reg_w = 1'b0; mem_w = 1'b0;
        alu_flags = 4'h0; cond = 4'h0;
        reset = 1'b1;
        step();
    endtask

    task automatic test_basic_flow();
        cond = 4'b0000; latch = 1'b1; step();
        n_cmp++; if (cond_ex[0] !== 1'b0) begin n_bad++; $display("FAIL eq_zero_condex got=%b exp=0", cond_ex[0]); end
        n_cmp++; if (skip0 !== 16'd1) begin n_bad++; $display("FAIL eq_zero_skip got=%0d exp=1", skip0); end
        alu_flags = 4'b0100; flag_w = 2'b10; cond = 4'b1110; latch = 1'b1; step();
        n_cmp++; if (flags[0] !== 4'b0000) begin n_bad++; $display("FAIL write_gated_by_old got=%b exp=0000", flags[0]); end
        n_cmp++; if (cond_ex[0] !== 1'b1) begin n_bad++; $display("FAIL al_condex got=%b exp=1", cond_ex[0]); end
        latch = 1'b0; step();
        n_cmp++; if (flags[0] !== 4'b0100) begin n_bad++; $display("FAIL nz_write got=%b exp=0100", flags[0]); end
        flag_w = 2'b00; cond = 4'b0000; latch = 1'b1; step();
        n_cmp++; if (cond_ex[0] !== 1'b1) begin n_bad++; $display("FAIL eq_set_condex got=%b exp=1", cond_ex[0]); end
        n_cmp++; if (skip0 !== 16'd1) begin n_bad++; $display("FAIL eq_set_skip got=%0d exp=1", skip0); end
        latch = 1'b0;
    endtask

    task automatic test_half_write();
        flag_w = 2'b11; alu_flags = 4'b0000; step();
        n_cmp++; if (flags[0] !== 4'b0000) begin n_bad++; $display("FAIL clear_flags got=%b exp=0000", flags[0]); end
        flag_w = 2'b01; alu_flags = 4'b1111; step();
        n_cmp++; if (flags[0] !== 4'b0011) begin n_bad++; $display("FAIL cv_only got=%b exp=0011", flags[0]); end
        flag_w = 2'b00; cond = 4'b0000; latch = 1'b1; step();
        latch = 1'b0;
        n_cmp++; if (cond_ex[0] !== 1'b0) begin n_bad++; $display("FAIL fail_latch got=%b exp=0", cond_ex[0]); end
        flag_w = 2'b11; alu_flags = 4'b1100; step();
        n_cmp++; if (flags[0] !== 4'b0011) begin n_bad++; $display("FAIL gated_write got=%b exp=0011", flags[0]); end
        flag_w = 2'b00;
    endtask

    task automatic test_sweep();
        logic e0, e1;
        for (int f = 0; f < 16; f++) begin
            cond = 4'hE; latch = 1'b1; flag_w = 2'b00; step();
            latch = 1'b0; flag_w = 2'b11; alu_flags = 4'(f); step();
            flag_w = 2'b00;
            n_cmp++; if (flags[0] !== 4'(f)) begin n_bad++; $display("FAIL sweep_flags got=%b exp=%b", flags[0], 4'(f)); end
            for (int c = 0; c < 16; c++) begin
                cond = 4'(c); latch = 1'b1; step();
                e0 = exp_cond(4'(c), 4'(f), 1'b0);
                e1 = exp_cond(4'(c), 4'(f), 1'b1);
                n_cmp++; if (cond_ex[0] !== e0) begin n_bad++; $display("FAIL sweep_nv0 cond=%b flags=%b got=%b exp=%b", 4'(c), 4'(f), cond_ex[0], e0); end
                n_cmp++; if (cond_ex[1] !== e1) begin n_bad++; $display("FAIL sweep_nv1 cond=%b flags=%b got=%b exp=%b", 4'(c), 4'(f), cond_ex[1], e1); end
            end
            latch = 1'b0;
        end
    endtask

    task automatic test_banks();
        bank_sel = 1'b0; cond = 4'hE; latch = 1'b1; step();
        latch = 1'b0; flag_w = 2'b11; alu_flags = 4'b1000; step();
        bank_sel = 1'b1; alu_flags = 4'b0001; step();
        flag_w = 2'b00;
        n_cmp++; if (flags[0] !== 4'b0001) begin n_bad++; $display("FAIL bank1_write got=%b exp=0001", flags[0]); end
        bank_sel = 1'b0; #1;
        n_cmp++; if (flags[0] !== 4'b1000) begin n_bad++; $display("FAIL bank0_write got=%b exp=1000", flags[0]); end
        bank_sel = 1'b1; flag_save = 1'b1; step();
        flag_save = 1'b0; flag_w = 2'b11; alu_flags = 4'b0110; step();
        n_cmp++; if (flags[0] !== 4'b0110) begin n_bad++; $display("FAIL bank1_over got=%b exp=0110", flags[0]); end
        bank_sel = 1'b0; #1;
        n_cmp++; if (flags[0] !== 4'b1000) begin n_bad++; $display("FAIL bank0_hold got=%b exp=1000", flags[0]); end
        bank_sel = 1'b1; flag_restore = 1'b1; alu_flags = 4'b1111; step();
        flag_restore = 1'b0; flag_w = 2'b00;
        n_cmp++; if (flags[0] !== 4'b0001) begin n_bad++; $display("FAIL restore got=%b exp=0001", flags[0]); end
        bank_sel = 1'b0; #1;
        n_cmp++; if (flags[0] !== 4'b1000) begin n_bad++; $display("FAIL bank0_after got=%b exp=1000", flags[0]); end
        flag_save = 1'b1; flag_restore = 1'b1; step();
        flag_save = 1'b0; flag_restore = 1'b0;
        n_cmp++; if (flags[0] !== 4'b0001) begin n_bad++; $display("FAIL swap_bank got=%b exp=0001", flags[0]); end
        flag_restore = 1'b1; step();
        flag_restore = 1'b0;
        n_cmp++; if (flags[0] !== 4'b1000) begin n_bad++; $display("FAIL swap_saved got=%b exp=1000", flags[0]); end
    endtask

    task automatic test_skip_saturate();
        logic [1:0] exp_seq [5];
        exp_seq = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        bank_sel = 1'b0; cnt_clr = 1'b1; latch = 1'b0; step();
        cnt_clr = 1'b0;
        n_cmp++; if (skip2 !== 2'd0) begin n_bad++; $display("FAIL skip_clr got=%0d exp=0", skip2); end
        cond = 4'b0000;
        for (int k = 0; k < 5; k++) begin
            latch = 1'b1; step();
            n_cmp++; if (skip2 !== exp_seq[k]) begin n_bad++; $display("FAIL skip_seq%0d got=%0d exp=%0d", k, skip2, exp_seq[k]); end
        end
        n_cmp++; if (skip0 !== 16'd5) begin n_bad++; $display("FAIL skip_wide got=%0d exp=5", skip0); end
        cnt_clr = 1'b1; step();
        cnt_clr = 1'b0; latch = 1'b0;
        n_cmp++; if (skip2 !== 2'd0) begin n_bad++; $display("FAIL skip_clr_prio got=%0d exp=0", skip2); end
        n_cmp++; if (skip0 !== 16'd0) begin n_bad++; $display("FAIL skip_wide_clr got=%0d exp=0", skip0); end
    endtask

    task automatic test_gating();
        cond = 4'hE; latch = 1'b1; step();
        latch = 1'b0; pcs = 1'b1; next_pc = 1'b0; reg_w = 1'b1; mem_w = 1'b1; #1;
        n_cmp++; if (pc_write[0] !== 1'b1) begin n_bad++; $display("FAIL gate_pcs got=%b exp=1", pc_write[0]); end
        n_cmp++; if (reg_write[0] !== 1'b1) begin n_bad++; $display("FAIL gate_reg got=%b exp=1", reg_write[0]); end
        n_cmp++; if (mem_write[0] !== 1'b1) begin n_bad++; $display("FAIL gate_mem got=%b exp=1", mem_write[0]); end
        cond = 4'b0000; latch = 1'b1; step();
        latch = 1'b0;
        n_cmp++; if (pc_write[0] !== 1'b0) begin n_bad++; $display("FAIL block_pcs got=%b exp=0", pc_write[0]); end
        n_cmp++; if (reg_write[0] !== 1'b0) begin n_bad++; $display("FAIL block_reg got=%b exp=0", reg_write[0]); end
        n_cmp++; if (mem_write[0] !== 1'b0) begin n_bad++; $display("FAIL block_mem got=%b exp=0", mem_write[0]); end
        next_pc = 1'b1; #1;
        n_cmp++; if (pc_write[0] !== 1'b1) begin n_bad++; $display("FAIL nextpc got=%b exp=1", pc_write[0]); end
        next_pc = 1'b0; pcs = 1'b0; reg_w = 1'b0; mem_w = 1'b0;
    endtask

    task automatic test_async_reset();
        bank_sel = 1'b0; cond = 4'hE; latch = 1'b1; step();
        latch = 1'b0; reg_w = 1'b1; next_pc = 1'b1; #1;
        n_cmp++; if (reg_write[0] !== 1'b1) begin n_bad++; $display("FAIL pre_rst_reg got=%b exp=1", reg_write[0]); end
        n_cmp++; if (flags[0] !== 4'b1000) begin n_bad++; $display("FAIL pre_rst_flags got=%b exp=1000", flags[0]); end
        #1 reset = 1'b0;
        #1;
        n_cmp++; if (reg_write[0] !== 1'b0) begin n_bad++; $display("FAIL arst_reg got=%b exp=0", reg_write[0]); end
        n_cmp++; if (flags[0] !== 4'b0000) begin n_bad++; $display("FAIL arst_flags got=%b exp=0000", flags[0]); end
        n_cmp++; if (cond_ex[0] !== 1'b0) begin n_bad++; $display("FAIL arst_condex got=%b exp=0", cond_ex[0]); end
        n_cmp++; if (pc_write[0] !== 1'b1) begin n_bad++; $display("FAIL arst_pcwrite got=%b exp=1", pc_write[0]); end
        step();
        reset = 1'b1; reg_w = 1'b0; next_pc = 1'b0;
        step();
        n_cmp++; if (cond_ex[0] !== 1'b0) begin n_bad++; $display("FAIL post_rst_condex got=%b exp=0", cond_ex[0]); end
    endtask

    initial begin
        test_reset();
        test_basic_flow();
        test_half_write();
        test_sweep();
        test_banks();
        test_skip_saturate();
        test_gating();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cond_unit.md
COND_UNIT -- requirements
Module: cond_unit

Interface
REQ-001 Parameter NBANK, default 2: number of independent NZCV flag banks, at least 1.
REQ-002 Parameter BSW, default $clog2(NBANK) (1 when NBANK=1): BankSel width.
REQ-003 Parameter CNT_W, default 16: width of the skipped-instruction counter.
REQ-004 Parameter NV_EXEC, default 0: 0 means Cond=1111 evaluates false (never); 1 means it evaluates true (unconditional space).
REQ-005 clk  in  1  rising-edge clock, sole clock.
REQ-006 reset  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-007 Cond  in  4  ARM condition field of the current instruction.
REQ-008 ALUFlags  in  4  {N,Z,C,V} produced by the ALU.
REQ-009 FlagW  in  2  bit1 requests an N,Z update; bit0 requests a C,V update.
REQ-010 BankSel  in  BSW  selects the active flag bank for evaluation, write, save and restore.
REQ-011 Latch  in  1  captures the condition result; asserted in the decode state.
REQ-012 PCS, NextPC, RegW, MemW  in  1 each  ungated controller write requests.
REQ-013 FlagSave, FlagRestore  in  1 each  copy active bank to saved register, or saved register to active bank.
REQ-014 CntClr  in  1  synchronous clear of the skip counter.
REQ-015 PCWrite, RegWrite, MemWrite  out  1 each  condition-gated write enables.
REQ-016 CondEx  out  1  registered condition result (CondEx_q).
REQ-017 Flags  out  4  current {N,Z,C,V} of the selected bank.
REQ-018 SkipCnt  out  CNT_W  number of latched instructions whose condition failed.

Function
REQ-019 Combinational evaluation of Cond against Flags of BankSel shall follow this table. Let ge = (N==V).
- 0000 EQ: Z. 0001 NE: !Z.
- 0010 CS: C. 0011 CC: !C.
- 0100 MI: N. 0101 PL: !N.
- 0110 VS: V. 0111 VC: !V.
- 1000 HI: C&!Z. 1001 LS: !(C&!Z).
- 1010 GE: ge. 1011 LT: !ge.
- 1100 GT: !Z&ge. 1101 LE: !(!Z&ge).
- 1110 AL: 1. 1111: NV_EXEC.
REQ-020 On a rising edge with Latch=1, CondEx_q shall load the REQ-019 result, which is computed from pre-edge flags; with Latch=0 it shall hold.
REQ-021 Gating shall use CondEx_q only:
- PCWrite = NextPC | (PCS & CondEx_q)
- RegWrite = RegW & CondEx_q
- MemWrite = MemW & CondEx_q
REQ-022 At an edge with FlagW[1]&CondEx_q, bank[BankSel] N,Z shall load ALUFlags[3:2]; with FlagW[0]&CondEx_q, C,V shall load ALUFlags[1:0]; halves update independently.
REQ-023 Non-selected banks shall never change except on reset.
REQ-024 FlagSave at an edge shall load the saved register with the pre-edge Flags of the selected bank.
REQ-025 FlagRestore at an edge shall load bank[BankSel] from the saved register and shall override any FlagW write that edge.
REQ-026 FlagSave and FlagRestore together shall swap: saved gets the old bank value and the bank gets the old saved value.
REQ-027 At an edge with Latch=1 and a false REQ-019 result, SkipCnt shall increment by 1 and saturate at all-ones.
REQ-028 CntClr shall zero SkipCnt and shall take priority over an increment in the same cycle.
REQ-029 Flags is combinational from bank[BankSel]; changing BankSel shall take effect in the same cycle.
REQ-030 Latch and a flag write in the same cycle: the latch shall use pre-write flags, and the write shall be gated by the old CondEx_q.

Reset
REQ-031 While reset=0, asynchronously: all banks = 0000, saved register = 0000, CondEx_q = 0, SkipCnt = 0.
REQ-032 During reset, PCWrite = NextPC, RegWrite = 0, MemWrite = 0, Flags = 0000.
REQ-033 Reset asserted mid-instruction shall discard the latched CondEx; there is no recovery state.

Verification
REQ-034 After reset, Cond=0000 (EQ) with Latch=1 -> CondEx=0 and SkipCnt=1; then ALUFlags=0100, FlagW=10, Cond=1110 (AL) with Latch=1 for one edge, then FlagW=10 for the next edge -> Flags=0100, then Cond=0000 with Latch=1 -> CondEx=1.
REQ-035 CondEx_q=1, FlagW=01, ALUFlags=1111 -> Flags=0011 (N,Z unchanged); with CondEx_q=0 and FlagW=11 -> Flags unchanged.
REQ-036 Sweep all 16 Cond values against all 16 flag values with NV_EXEC=0 and NV_EXEC=1 -> CondEx matches REQ-019 at every point, including GE/LT/GT/LE for N!=V.
REQ-037 NBANK=2: write bank0 = 1000 and bank1 = 0001; FlagSave on bank1, write bank1 = 0110, then FlagRestore -> bank1 = 0001 and bank0 = 1000 throughout.
REQ-038 CNT_W=2: five Latch edges with a failing Cond -> SkipCnt = 1, 2, 3, 3, 3; CntClr and a failing Latch on the same edge -> SkipCnt = 0.
REQ-039 reset asserted asynchronously between edges while CondEx_q=1 and RegW=1 -> RegWrite falls immediately, and Flags reads 0000.
